// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: oversampled frame capture, make/break/extended decode,
// and held/press/release tracking for a configurable set of scan codes.
module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = 32'h5A_75_76_29,
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b0100,
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PS2_clk,
  input  logic                PS2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          scan_code,
  output logic                scan_valid,
  output logic                frame_error
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_p0;
  logic          par_p0;
  logic [TW-1:0] to_cnt;

  logic                ext;
  logic                brk;
  logic [NUM_KEYS-1:0] match;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Synchroniser stage: idle-high lines reset to 1 so release never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_data};
      clk_prev  <= clk_s;
    end
  end

  // Frame stage: shift, validate, publish byte at T+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_p0    <= '0;
      par_p0      <= 1'b0;
      to_cnt      <= '0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift_p0 <= {data_s, shift_p0[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_p0 <= data_s;
            state  <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (data_s && odd_parity_ok(shift_p0, par_p0)) begin
              scan_code  <= shift_p0;
              scan_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_MAX) begin
        state       <= ST_IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEY_CODES[8*i +: 8] == scan_code) && (KEY_EXT[i] == ext);
    end
  end

  // Key stage: prefix flags and per-key state, registered at T+2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (scan_valid) begin
        if (scan_code == CODE_EXT) begin
          ext <= 1'b1;
        end else if (scan_code == CODE_BRK) begin
          brk <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i]) begin
              if (brk) begin
                key_held[i]    <= 1'b0;
                key_release[i] <= key_held[i];
              end else if (!key_held[i]) begin
                key_held[i]  <= 1'b1;
                key_press[i] <= 1'b1;
              end
            end
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven on the raw PS/2 pins, pulses counted.
module tb_ps2_key_decoder;

  localparam int NK = 4;
  localparam int TO = 50000;
  localparam int H  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          PS2_clk = 1'b1;
  logic          PS2_data = 1'b1;
  logic [NK-1:0] key_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [7:0]    scan_code;
  logic          scan_valid;
  logic          frame_error;

  ps2_key_decoder #(
    .NUM_KEYS(NK), .KEY_CODES(32'h5A_75_76_29), .KEY_EXT(4'b0100),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
    .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int sv_cyc = 0;
  int press_cnt [NK];
  int rel_cnt [NK];
  int press_cyc [NK];
  int rel_cyc [NK];

  initial begin
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_cyc[i] = 0; rel_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (scan_valid) begin sv_cnt++; sv_cyc = cyc; end
    if (frame_error) fe_cnt++;
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (key_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    PS2_data = b;
    wait_cyc(H);
    PS2_clk = 1'b0;
    wait_cyc(H);
    PS2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    PS2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_partial(input int ndata);
    send_bit(1'b0);
    for (int i = 0; i < ndata; i++) send_bit(1'b1);
    PS2_data = 1'b1;
  endtask

  int sv0, fe0;

  initial begin
    wait_cyc(5);
    check_val("reset_outputs",
              {8'h0, key_held, key_press, key_release, scan_code, scan_valid, frame_error}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);
    check_val("idle_after_reset", {28'h0, key_held}, 32'h0);

    // Make then break of key 0
    send_frame(8'h29, 1'b0);
    check_val("k0_press_cnt", press_cnt[0], 1);
    check_val("k0_held", {28'h0, key_held}, 32'h1);
    check_val("sv_cnt_1", sv_cnt, 1);
    check_val("scan_code_29", {24'h0, scan_code}, 32'h29);
    check_val("press_lat", press_cyc[0] - sv_cyc, 1);
    send_frame(8'hF0, 1'b0);
    check_val("scan_code_f0", {24'h0, scan_code}, 32'hF0);
    send_frame(8'h29, 1'b0);
    check_val("k0_rel_cnt", rel_cnt[0], 1);
    check_val("rel_lat", rel_cyc[0] - sv_cyc, 1);
    check_val("k0_released", {28'h0, key_held}, 32'h0);
    check_val("sv_cnt_3", sv_cnt, 3);

    // Typematic repeats
    send_frame(8'h29, 1'b0);
    send_frame(8'h29, 1'b0);
    send_frame(8'h29, 1'b0);
    check_val("typematic_press", press_cnt[0], 2);
    check_val("typematic_held", {28'h0, key_held}, 32'h1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    check_val("typematic_rel", rel_cnt[0], 2);

    // Extended key
    send_frame(8'h75, 1'b0);
    check_val("non_ext_75", {28'h0, key_held}, 32'h0);
    check_val("non_ext_75_press", press_cnt[2], 0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_val("ext_press", press_cnt[2], 1);
    check_val("ext_held", {28'h0, key_held}, 32'h4);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_val("ext_rel", rel_cnt[2], 1);
    check_val("ext_released", {28'h0, key_held}, 32'h0);

    // Parity error
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(8'h76, 1'b1);
    check_val("par_err_fe", fe_cnt, fe0 + 1);
    check_val("par_err_sv", sv_cnt, sv0);
    check_val("par_err_held", {28'h0, key_held}, 32'h0);
    send_frame(8'h76, 1'b0);
    check_val("k1_press", press_cnt[1], 1);
    check_val("k1_held", {28'h0, key_held}, 32'h2);

    // Timeout on a partial frame
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_partial(4);
    wait_cyc(TO - 200);
    check_val("pre_timeout_fe", fe_cnt, fe0);
    wait_cyc(300);
    check_val("timeout_fe", fe_cnt, fe0 + 1);
    check_val("timeout_sv", sv_cnt, sv0);
    send_frame(8'h5A, 1'b0);
    check_val("k3_press", press_cnt[3], 1);
    check_val("k3_held", {28'h0, key_held}, 32'hA);

    // Unmatched byte clears the break flag
    send_frame(8'hF0, 1'b0);
    send_frame(8'hAA, 1'b0);
    send_frame(8'h76, 1'b0);
    check_val("unmatched_clr_brk", {28'h0, key_held}, 32'hA);
    check_val("unmatched_no_rel", rel_cnt[1], 0);

    // Reset mid-frame with key 0 held
    send_frame(8'h29, 1'b0);
    check_val("pre_rst_held", {28'h0, key_held}, 32'hB);
    send_partial(3);
    rst = 1'b1;
    #1;
    check_val("rst_mid_frame",
              {8'h0, key_held, key_press, key_release, scan_code, scan_valid, frame_error}, 32'h0);
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4);
    sv0 = press_cnt[0];
    send_frame(8'h29, 1'b0);
    check_val("post_rst_press", press_cnt[0], sv0 + 1);
    check_val("post_rst_held", {28'h0, key_held}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and key-state tracker, clocked entirely in the system `clk` domain. It oversamples the keyboard's `PS2_clk`/`PS2_data` lines, validates each 11-bit frame (start, parity, stop), decodes make, break (`F0`) and extended (`E0`) sequences, and tracks held/pressed/released state for a configurable set of keys. It sits between the board PS/2 pins and game control logic (flap, pause, menu), replacing ad-hoc single-key decoding.

## Interface
- `NUM_KEYS`, 4: number of monitored keys.
- `KEY_CODES`, 32'h5A_75_76_29: packed NUM_KEYS×8 scan codes; key i = `KEY_CODES[8i+7:8i]` (default: 0 space, 1 esc, 2 up-arrow, 3 enter).
- `KEY_EXT`, 4'b0100: bit i = 1 means key i requires the `E0` prefix.
- `SYNC_STAGES`, 2: synchroniser depth on both PS/2 lines, ≥ 2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a PS/2 falling edge before a partial frame is aborted.

- `clk`  in  1  system clock, ≥ 1 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `PS2_clk`  in  1  raw keyboard clock, asynchronous.
- `PS2_data`  in  1  raw keyboard data, asynchronous.
- `key_held`  out  NUM_KEYS  level; bit i high while key i is down.
- `key_press`  out  NUM_KEYS  one-cycle pulse on the make of key i (not on typematic repeats).
- `key_release`  out  NUM_KEYS  one-cycle pulse on the break of a held key i.
- `scan_code`  out  8  last valid received byte.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_error`  out  1  one-cycle pulse on parity error, stop error or timeout.

## Operation
- Both PS/2 lines pass through `SYNC_STAGES` flops. A falling edge is detected when the previous synchronised clock is 1 and the current one is 0; data is sampled in that cycle.
- Frame FSM states:
  - IDLE: an edge with data 0 → DATA with bit count 0. An edge with data 1 is ignored; no error is raised.
  - DATA: each edge shifts data in LSB first; after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: capture the stop bit. The frame is valid if stop = 1 and XOR(data[7:0], parity) = 1 (odd parity); otherwise `frame_error` pulses. Either way → IDLE.
- Timeout: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on every edge and in IDLE. Outside IDLE, when it reaches TIMEOUT_CYCLES−1 the FSM returns to IDLE, `frame_error` pulses and the partial frame is discarded. An edge in the same cycle takes priority over the timeout.
- Protocol layer, acting on each valid byte b (`scan_valid` pulses for every valid byte, prefixes included):
  - b = E0: set `ext`.
  - b = F0: set `brk`.
  - Any other b: for every i with `KEY_CODES[i]` = b and `KEY_EXT[i]` = `ext`:
    - `brk` = 1: clear `key_held[i]`; pulse `key_release[i]` only if the key was held.
    - `brk` = 0: if the key is not held, set `key_held[i]` and pulse `key_press[i]`; a repeat make while held produces no pulse.
  - Then clear `brk` and `ext`. Unmatched bytes (e.g. AA, FA) simply clear both flags.
- Duplicate entries in `KEY_CODES` all update together. Several keys can be held at once.
- An invalid frame leaves `brk`/`ext` unchanged.

## Timing
- Reset values: `key_held`, `key_press`, `key_release`, `scan_code`, `scan_valid`, `frame_error` all 0. FSM in IDLE, `brk` = `ext` = 0, timeout counter 0.
- Reset mid-frame discards the partial bits; the next frame must begin with a start bit.
- Let cycle T be the cycle in which the stop-bit edge is detected (SYNC_STAGES+1 cycles after the raw `PS2_clk` fall):
  - `scan_code`, `scan_valid` and `frame_error` are registered at T+1.
  - `key_held`, `key_press` and `key_release` are registered at T+2.
- Pulses are exactly one `clk` cycle wide. All outputs are registered.
- Minimum spacing between PS/2 edges is 30 µs, so back-to-back frames never overlap the 2-cycle decode pipeline.

## Test plan
- Frame 0x29, correct parity, then frames F0, 29 → `key_press[0]` pulse and `key_held[0]` = 1 at T+2 of the first frame; `key_release[0]` pulse and `key_held[0]` = 0 after the third frame; `scan_valid` pulses 3 times.
- Frames 29, 29, 29 (typematic) → exactly one `key_press[0]` pulse; `key_held[0]` stays 1.
- Frame 0x75 alone → no key change. Frames E0, 75 → `key_press[2]`. Frames E0, F0, 75 → `key_release[2]`.
- Frame 0x76 with a wrong parity bit → `frame_error` pulse, no `scan_valid`, `key_held` = 0. A following correct 0x76 → `key_press[1]`.
- Start bit plus 4 data bits, then PS/2 idle for 50000 cycles → `frame_error` pulse at the timeout, FSM in IDLE. A following valid 0x5A → `key_press[3]`.
- Assert `rst` mid-frame while key 0 is held → all outputs 0 immediately. A fresh frame 0x29 after release of `rst` → `key_press[0]` pulse.
